// File: rtl/alu_sequencer.sv
// Bus-side initiator for the two-register ALU: loads ula(0)/ula(1) over the shared bus,
// issues the compute op, captures the ALU's drive and returns it on a valid/ready port.
//
// state | meaning
// IDLE  | bus released, waiting for a granted command
// WR0   | driving A onto the bus, ALU writes ula(0)
// WR1   | driving B onto the bus, ALU writes ula(1)
// EXEC  | compute op issued, bus idle
// CAPT  | ALU drives the result; sampled on the closing edge
// RESP  | result held on the response port until consumed
module alu_sequencer #(
    parameter int BITW = 8,
    parameter int OPW  = 3
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic            bus_gnt,
    input  logic            shadow_inv,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_kind,
    input  logic [BITW-1:0] cmd_a,
    input  logic [BITW-1:0] cmd_b,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [BITW-1:0] res_data,
    output logic            res_zero,
    output logic            busy,
    output logic [OPW-1:0]  alu_op,
    inout  wire  [BITW-1:0] bus
);

    localparam logic [OPW-1:0] ALU_NOP      = OPW'(0);
    localparam logic [OPW-1:0] ALU_ADD      = OPW'(1);
    localparam logic [OPW-1:0] ALU_SUB      = OPW'(2);
    localparam logic [OPW-1:0] ALU_INC      = OPW'(3);
    localparam logic [OPW-1:0] ALU_WRITE_R0 = OPW'(4);
    localparam logic [OPW-1:0] ALU_WRITE_R1 = OPW'(5);

    localparam logic [1:0] KIND_SUB = 2'b01;
    localparam logic [1:0] KIND_INC = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        WR1  = 3'd2,
        EXEC = 3'd3,
        CAPT = 3'd4,
        RESP = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      kind_q;
    logic [BITW-1:0] a_q, b_q;
    logic            need_wr1_q;
    logic [BITW-1:0] shadow0_q, shadow1_q;
    logic            valid0_q, valid1_q;
    logic            res_valid_q, res_zero_q;
    logic [BITW-1:0] res_data_q;

    logic            accept;
    logic            skip_wr0, skip_wr1;
    logic            drive_en;
    logic [BITW-1:0] drive_data;

    // An invalidate seen on the accept edge already counts against the shadows.
    assign skip_wr0 = (cmd_kind == KIND_INC) ||
                      (valid0_q && !shadow_inv && (shadow0_q == cmd_a));
    assign skip_wr1 = valid1_q && !shadow_inv && (shadow1_q == cmd_b);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        accept     = 1'b0;
        alu_op     = ALU_NOP;
        drive_en   = 1'b0;
        drive_data = '0;
        case (state_q)
            IDLE: begin
                cmd_ready = bus_gnt & n_reset;
                accept    = cmd_valid & bus_gnt & n_reset;
                if (accept) begin
                    if (!skip_wr0)      state_d = WR0;
                    else if (!skip_wr1) state_d = WR1;
                    else                state_d = EXEC;
                end
            end
            WR0: begin
                alu_op     = ALU_WRITE_R0;
                drive_en   = 1'b1;
                drive_data = a_q;
                state_d    = need_wr1_q ? WR1 : EXEC;
            end
            WR1: begin
                alu_op     = ALU_WRITE_R1;
                drive_en   = 1'b1;
                drive_data = b_q;
                state_d    = EXEC;
            end
            EXEC: begin
                case (kind_q)
                    KIND_SUB: alu_op = ALU_SUB;
                    KIND_INC: alu_op = ALU_INC;
                    default:  alu_op = ALU_ADD;
                endcase
                state_d = CAPT;
            end
            CAPT: state_d = RESP;
            RESP: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            kind_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            need_wr1_q  <= 1'b0;
            shadow0_q   <= '0;
            shadow1_q   <= '0;
            valid0_q    <= 1'b0;
            valid1_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
        end else begin
            if (accept) begin
                kind_q     <= cmd_kind;
                a_q        <= cmd_a;
                b_q        <= cmd_b;
                need_wr1_q <= !skip_wr1;
            end
            if (state_q == WR0) begin
                shadow0_q <= a_q;
                valid0_q  <= 1'b1;
            end
            if (state_q == WR1) begin
                shadow1_q <= b_q;
                valid1_q  <= 1'b1;
            end
            if (shadow_inv) begin
                valid0_q <= 1'b0;
                valid1_q <= 1'b0;
            end
            if (state_q == CAPT) begin
                res_data_q  <= bus;
                res_zero_q  <= (bus == '0);
                res_valid_q <= 1'b1;
            end
            if (state_q == RESP && res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus       = drive_en ? drive_data : 'z;
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU sits on the bus, a scoreboard queue holds the
// expected result/latency per accepted command, and a negedge monitor checks responses and bus use.
module tb_alu_sequencer;

    localparam logic [2:0] OP_NOP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_INC = 3'd3;
    localparam logic [2:0] OP_WR0 = 3'd4, OP_WR1 = 3'd5;
    localparam logic [7:0] BUS_IDLE = 8'hFF;

    logic       clock = 1'b0;
    logic       n_reset, bus_gnt, shadow_inv, cmd_valid, res_ready;
    logic       cmd_ready, res_valid, res_zero, busy;
    logic [1:0] cmd_kind;
    logic [7:0] cmd_a, cmd_b, res_data;
    logic [2:0] alu_op;
    wire  [7:0] bus;

    alu_sequencer #(.BITW(8), .OPW(3)) dut (
        .clock(clock), .n_reset(n_reset), .bus_gnt(bus_gnt), .shadow_inv(shadow_inv),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero), .busy(busy), .alu_op(alu_op), .bus(bus)
    );

    always #5 clock = ~clock;

    // Undriven bus reads back as all ones.
    pullup pu_bus (bus);

    // Behavioural two-register ALU: drives its result in the cycle after a compute op.
    logic [7:0] r0, r1, alu_res;
    logic       alu_drv;
    always @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            alu_drv <= 1'b0;
        end else begin
            alu_drv <= 1'b0;
            case (alu_op)
                OP_WR0: r0 <= bus;
                OP_WR1: r1 <= bus;
                OP_ADD: begin alu_res <= r0 + r1; alu_drv <= 1'b1; end
                OP_SUB: begin alu_res <= r0 - r1; alu_drv <= 1'b1; end
                OP_INC: begin alu_res <= r1 + 8'd1; alu_drv <= 1'b1; end
                default: ;
            endcase
        end
    end
    assign bus = alu_drv ? alu_res : 'z;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expired(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: awaited event did not occur within bound (t=%0t)", name, $time);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       zero;
        int         lat;
        int         c0;
    } exp_t;
    exp_t sbq[$];

    // Reference shadow knowledge: what ula(0)/ula(1) are known to hold.
    logic [7:0] m_s0, m_s1;
    bit         m_v0, m_v1;
    logic [7:0] cur_a, cur_b;

    function automatic logic [7:0] ref_result(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b);
        int r;
        if (k == 2'b01)      r = int'(a) - int'(b);
        else if (k == 2'b10) r = int'(b) + 1;
        else                 r = int'(a) + int'(b);
        return 8'(r % 256 + 256);
    endfunction

    function automatic logic [2:0] ref_op(input logic [1:0] k);
        if (k == 2'b01) return OP_SUB;
        if (k == 2'b10) return OP_INC;
        return OP_ADD;
    endfunction

    // Scoreboard monitor plus per-cycle bus ownership checks.
    bit   prev_rv = 1'b0;
    exp_t mon_e;
    always @(negedge clock) begin
        if (!n_reset) begin
            prev_rv = 1'b0;
        end else begin
            if (res_valid && !prev_rv) begin
                if (sbq.size() == 0) begin
                    expired("sb_unexpected_result");
                end else begin
                    mon_e = sbq.pop_front();
                    chk("res_data", res_data, mon_e.data);
                    chk("res_zero", res_zero, mon_e.zero);
                    chk("latency", cyc - mon_e.c0, mon_e.lat);
                end
            end
            prev_rv = res_valid;
            if (alu_drv) begin
                chk("one_driver", (alu_op == OP_WR0 || alu_op == OP_WR1), 0);
                chk("bus_capt_known", $isunknown(bus), 0);
                chk("bus_capt_value", bus, alu_res);
            end else if (alu_op == OP_WR0) begin
                chk("bus_wr0", bus, cur_a);
            end else if (alu_op == OP_WR1) begin
                chk("bus_wr1", bus, cur_b);
            end else begin
                chk("bus_release", bus, BUS_IDLE);
            end
        end
    end

    task automatic clear_model();
        m_v0 = 0; m_v1 = 0; m_s0 = '0; m_s1 = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        n_reset = 1'b0;
        clear_model();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_zero", res_zero, 0);
        chk("rst_alu_op", alu_op, OP_NOP);
        chk("rst_bus", bus, BUS_IDLE);
        repeat (2) @(negedge clock);
        n_reset = 1'b1;
    endtask

    task automatic inv_pulse();
        @(negedge clock);
        shadow_inv = 1'b1;
        m_v0 = 0; m_v1 = 0;
        @(negedge clock);
        shadow_inv = 1'b0;
    endtask

    task automatic issue(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b,
                         input int hold, input bit abort, input bit drop_gnt, input bit pre_nogrant);
        bit         l0, l1;
        int         n;
        exp_t       e;
        logic [7:0] ev;
        logic [2:0] eops[$];
        logic [2:0] seen[$];
        cmd_kind = k; cmd_a = a; cmd_b = b; cur_a = a; cur_b = b;
        cmd_valid = 1'b1;
        if (pre_nogrant) begin
            bus_gnt = 1'b0;
            @(negedge clock);
            chk("no_grant_ready", cmd_ready, 0);
            bus_gnt = 1'b1;
        end
        #1;
        n = 0;
        while (!cmd_ready) begin
            @(negedge clock);
            n++;
            if (n >= 50) begin
                expired("accept_timeout");
                cmd_valid = 1'b0;
                return;
            end
        end
        l0 = (k != 2'b10) && !(m_v0 && m_s0 == a);
        l1 = !(m_v1 && m_s1 == b);
        ev = ref_result(k, a, b);
        e.data = ev; e.zero = (ev == 8'h00); e.lat = 3 + int'(l0) + int'(l1); e.c0 = cyc;
        sbq.push_back(e);
        if (l0) eops.push_back(OP_WR0);
        if (l1) eops.push_back(OP_WR1);
        eops.push_back(ref_op(k));
        eops.push_back(OP_NOP);
        if (l0) begin m_s0 = a; m_v0 = 1; end
        if (l1) begin m_s1 = b; m_v1 = 1; end
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        if (drop_gnt) bus_gnt = 1'b0;
        n = 0;
        forever begin
            @(negedge clock);
            n++;
            if (res_valid) break;
            if (abort && alu_op == OP_WR1) begin
                n_reset = 1'b0;
                void'(sbq.pop_back());
                clear_model();
                #1;
                chk("abort_bus", bus, BUS_IDLE);
                chk("abort_busy", busy, 0);
                chk("abort_alu_op", alu_op, OP_NOP);
                repeat (2) @(negedge clock);
                n_reset = 1'b1;
                bus_gnt = 1'b1;
                repeat (3) begin
                    @(negedge clock);
                    chk("abort_no_result", res_valid, 0);
                    chk("abort_idle", busy, 0);
                end
                return;
            end
            seen.push_back(alu_op);
            if (n > 20) begin
                expired("result_timeout");
                bus_gnt = 1'b1;
                return;
            end
        end
        chk("op_count", seen.size(), eops.size());
        for (int i = 0; i < seen.size() && i < eops.size(); i++)
            chk("op_seq", seen[i], eops[i]);
        if (hold > 0) begin
            cmd_valid = 1'b1;
            repeat (hold) begin
                @(negedge clock);
                chk("hold_valid", res_valid, 1);
                chk("hold_data", res_data, ev);
                chk("hold_cmd_ready", cmd_ready, 0);
                chk("hold_alu_op", alu_op, OP_NOP);
                chk("hold_bus", bus, BUS_IDLE);
            end
            cmd_valid = 1'b0;
        end
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        res_ready = 1'b0;
        bus_gnt = 1'b1;
        chk("post_handshake_valid", res_valid, 0);
    endtask

    initial begin
        n_reset = 1'b0; bus_gnt = 1'b1; shadow_inv = 1'b0; cmd_valid = 1'b0;
        res_ready = 1'b0; cmd_kind = 2'b00; cmd_a = '0; cmd_b = '0;
        cur_a = '0; cur_b = '0;
        clear_model();
        do_reset();

        issue(2'b00, 8'h12, 8'h34, 0, 0, 0, 0);   // full load, 0x46
        issue(2'b01, 8'h12, 8'h34, 0, 0, 0, 0);   // no loads, 0xDE
        issue(2'b01, 8'h34, 8'h34, 0, 0, 0, 0);   // WR0 only, zero
        do_reset();
        issue(2'b10, 8'h77, 8'hFF, 0, 0, 0, 0);   // INC wraps to zero
        issue(2'b00, 8'h10, 8'h20, 4, 0, 0, 0);   // held response
        issue(2'b00, 8'h01, 8'h02, 0, 0, 0, 0);
        inv_pulse();
        issue(2'b00, 8'h01, 8'h02, 0, 0, 0, 0);
        issue(2'b00, 8'h05, 8'h06, 0, 1, 0, 0);   // reset during WR1
        issue(2'b00, 8'h05, 8'h06, 0, 0, 0, 0);
        issue(2'b11, 8'hF0, 8'h20, 1, 0, 1, 1);   // reserved kind, grant games

        for (int i = 0; i < 60; i++) begin
            logic [1:0] k;
            logic [7:0] a, b;
            k = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
            b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) inv_pulse();
            issue(k, a, b, int'($urandom_range(0, 3)), 0,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end

        repeat (3) @(negedge clock);
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
